// File: rtl/format_decoder_wide_if.sv
// ============================================================================
// Module   : format_decoder_wide_if
// Brief    : Fetch-group input and decoded-group output bundle of the decoder
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface format_decoder_wide_if #(
    parameter int NUM_LANES               = 4,
    parameter int addressWidth            = 64,
    parameter int instructionWidth        = 32,
    parameter int PidSize                 = 20,
    parameter int TidSize                 = 16,
    parameter int instructionCounterWidth = 64,
    parameter int opcodeSize              = 6,
    parameter int formatWidth             = 25
);
    logic                                         enable_i;
    logic [NUM_LANES-1:0]                         laneValid_i;
    logic [NUM_LANES*instructionWidth-1:0]        instruction_i;
    logic [addressWidth-1:0]                      instructionAddress_i;
    logic [PidSize-1:0]                           instructionPid_i;
    logic [TidSize-1:0]                           instructionTid_i;
    logic [instructionCounterWidth-1:0]           instructionMajId_i;
    logic                                         flush_i;
    logic                                         stall_i;
    logic                                         ready_o;
    logic                                         outputEnable_o;
    logic [NUM_LANES-1:0]                         laneValid_o;
    logic [NUM_LANES*formatWidth-1:0]             instFormat_o;
    logic [NUM_LANES*opcodeSize-1:0]              instOpcode_o;
    logic [NUM_LANES-1:0]                         illegal_o;
    logic [NUM_LANES*instructionWidth-1:0]        instruction_o;
    logic [NUM_LANES*addressWidth-1:0]            instructionAddress_o;
    logic [PidSize-1:0]                           instructionPid_o;
    logic [TidSize-1:0]                           instructionTid_o;
    logic [NUM_LANES*instructionCounterWidth-1:0] instructionMajId_o;

    modport slave (
        input  enable_i, laneValid_i, instruction_i, instructionAddress_i,
               instructionPid_i, instructionTid_i, instructionMajId_i,
               flush_i, stall_i,
        output ready_o, outputEnable_o, laneValid_o, instFormat_o, instOpcode_o,
               illegal_o, instruction_o, instructionAddress_o, instructionPid_o,
               instructionTid_o, instructionMajId_o
    );

    modport master (
        output enable_i, laneValid_i, instruction_i, instructionAddress_i,
               instructionPid_i, instructionTid_i, instructionMajId_i,
               flush_i, stall_i,
        input  ready_o, outputEnable_o, laneValid_o, instFormat_o, instOpcode_o,
               illegal_o, instruction_o, instructionAddress_o, instructionPid_o,
               instructionTid_o, instructionMajId_o
    );
endinterface

`default_nettype wire

// File: rtl/format_decoder_wide.sv
// ============================================================================
// Module   : format_decoder_wide
// Brief    : NUM_LANES-wide stage-1 format decoder feeding a DEPTH-entry queue
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module format_decoder_wide #(
    parameter int NUM_LANES               = 4,
    parameter int DEPTH                   = 2,
    parameter int addressWidth            = 64,
    parameter int instructionWidth        = 32,
    parameter int PidSize                 = 20,
    parameter int TidSize                 = 16,
    parameter int instructionCounterWidth = 64,
    parameter int opcodeSize              = 6,
    parameter int formatWidth             = 25
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    format_decoder_wide_if.slave bus
);
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    localparam int c_FMT_A   = 0;
    localparam int c_FMT_B   = 1;
    localparam int c_FMT_D   = 2;
    localparam int c_FMT_DQ  = 3;
    localparam int c_FMT_DS  = 4;
    localparam int c_FMT_DX  = 5;
    localparam int c_FMT_I   = 6;
    localparam int c_FMT_M   = 7;
    localparam int c_FMT_MD  = 8;
    localparam int c_FMT_MDS = 9;
    localparam int c_FMT_SC  = 10;
    localparam int c_FMT_VA  = 11;
    localparam int c_FMT_VC  = 12;
    localparam int c_FMT_VX  = 13;
    localparam int c_FMT_X   = 14;
    localparam int c_FMT_XFL = 15;
    localparam int c_FMT_XFX = 16;
    localparam int c_FMT_XL  = 17;
    localparam int c_FMT_XO  = 18;
    localparam int c_FMT_XS  = 19;
    localparam int c_FMT_XX2 = 20;
    localparam int c_FMT_XX3 = 21;
    localparam int c_FMT_XX4 = 22;
    localparam int c_FMT_Z22 = 23;
    localparam int c_FMT_Z23 = 24;

    // Primary-opcode table; opcodes shared by several formats return the OR.
    function automatic logic [formatWidth-1:0] fmt_lookup(input logic [opcodeSize-1:0] opc);
        logic [formatWidth-1:0] f;
        f = '0;
        case (opc) inside
            6'd2, 6'd3, 6'd7, 6'd8, 6'd10, 6'd11, 6'd12, 6'd13, 6'd14, 6'd15,
            [6'd24:6'd29], [6'd32:6'd55]:  f[c_FMT_D] = 1'b1;
            6'd4:  begin f[c_FMT_VA] = 1'b1; f[c_FMT_VC] = 1'b1; f[c_FMT_VX] = 1'b1; end
            6'd16: f[c_FMT_B]  = 1'b1;
            6'd17: f[c_FMT_SC] = 1'b1;
            6'd18: f[c_FMT_I]  = 1'b1;
            6'd19: begin f[c_FMT_XL] = 1'b1; f[c_FMT_DX] = 1'b1; end
            6'd20, 6'd21, 6'd23: f[c_FMT_M] = 1'b1;
            6'd30: begin f[c_FMT_MD] = 1'b1; f[c_FMT_MDS] = 1'b1; end
            6'd31: begin
                f[c_FMT_X]  = 1'b1; f[c_FMT_XO] = 1'b1;
                f[c_FMT_XFX] = 1'b1; f[c_FMT_XS] = 1'b1;
            end
            6'd56: f[c_FMT_DQ] = 1'b1;
            6'd57, 6'd58, 6'd62: f[c_FMT_DS] = 1'b1;
            6'd59: begin
                f[c_FMT_A] = 1'b1; f[c_FMT_X] = 1'b1;
                f[c_FMT_Z22] = 1'b1; f[c_FMT_Z23] = 1'b1;
            end
            6'd60: begin f[c_FMT_XX2] = 1'b1; f[c_FMT_XX3] = 1'b1; f[c_FMT_XX4] = 1'b1; end
            6'd61: begin f[c_FMT_DQ] = 1'b1; f[c_FMT_DS] = 1'b1; end
            6'd63: begin
                f[c_FMT_A] = 1'b1; f[c_FMT_X] = 1'b1; f[c_FMT_XFL] = 1'b1;
                f[c_FMT_Z22] = 1'b1; f[c_FMT_Z23] = 1'b1;
            end
            default: f = '0;
        endcase
        return f;
    endfunction

    wire [NUM_LANES*formatWidth-1:0]             dec_fmt;
    wire [NUM_LANES*opcodeSize-1:0]              dec_opc;
    wire [NUM_LANES-1:0]                         dec_ill;
    wire [NUM_LANES*instructionWidth-1:0]        dec_ins;
    wire [NUM_LANES*addressWidth-1:0]            dec_addr;
    wire [NUM_LANES*instructionCounterWidth-1:0] dec_maj;

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        wire                        lane_v = bus.laneValid_i[k];
        wire [instructionWidth-1:0] inst   = bus.instruction_i[k*instructionWidth +: instructionWidth];
        // IBM bit numbering: instruction bits 0:5 are the most significant bits.
        wire [opcodeSize-1:0]       opc    = inst[instructionWidth-1 -: opcodeSize];
        wire [formatWidth-1:0]      fmt    = fmt_lookup(opc);

        assign dec_fmt[k*formatWidth +: formatWidth]           = lane_v ? fmt : '0;
        assign dec_opc[k*opcodeSize +: opcodeSize]             = lane_v ? opc : '0;
        assign dec_ill[k]                                      = lane_v && (fmt == '0);
        assign dec_ins[k*instructionWidth +: instructionWidth] = lane_v ? inst : '0;
        assign dec_addr[k*addressWidth +: addressWidth] =
            lane_v ? (bus.instructionAddress_i + addressWidth'(4 * k)) : '0;
        assign dec_maj[k*instructionCounterWidth +: instructionCounterWidth] =
            lane_v ? (bus.instructionMajId_i + instructionCounterWidth'(k)) : '0;
    end

    logic [c_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_CNT_W-1:0] count_q, count_d;
    logic               ready;
    logic               out_valid;
    logic               push;
    logic               pop;

    assign ready     = (count_q != c_CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = bus.enable_i && ready && !bus.flush_i;
    assign pop       = out_valid && !bus.stall_i && !bus.flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + c_PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + c_PTR_W'(1);
            if (push && !pop)      count_d = count_q + c_CNT_W'(1);
            else if (pop && !push) count_d = count_q - c_CNT_W'(1);
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    logic [NUM_LANES-1:0]                         mem_lv_q   [DEPTH];
    logic [NUM_LANES*formatWidth-1:0]             mem_fmt_q  [DEPTH];
    logic [NUM_LANES*opcodeSize-1:0]              mem_opc_q  [DEPTH];
    logic [NUM_LANES-1:0]                         mem_ill_q  [DEPTH];
    logic [NUM_LANES*instructionWidth-1:0]        mem_ins_q  [DEPTH];
    logic [NUM_LANES*addressWidth-1:0]            mem_addr_q [DEPTH];
    logic [NUM_LANES*instructionCounterWidth-1:0] mem_maj_q  [DEPTH];
    logic [PidSize-1:0]                           mem_pid_q  [DEPTH];
    logic [TidSize-1:0]                           mem_tid_q  [DEPTH];

    // Payload storage needs no reset: outputs are masked whenever the queue is empty.
    always_ff @(posedge clock_i) begin
        if (push) begin
            mem_lv_q[wr_ptr_q]   <= bus.laneValid_i;
            mem_fmt_q[wr_ptr_q]  <= dec_fmt;
            mem_opc_q[wr_ptr_q]  <= dec_opc;
            mem_ill_q[wr_ptr_q]  <= dec_ill;
            mem_ins_q[wr_ptr_q]  <= dec_ins;
            mem_addr_q[wr_ptr_q] <= dec_addr;
            mem_maj_q[wr_ptr_q]  <= dec_maj;
            mem_pid_q[wr_ptr_q]  <= bus.instructionPid_i;
            mem_tid_q[wr_ptr_q]  <= bus.instructionTid_i;
        end
    end

    assign bus.ready_o              = ready;
    assign bus.outputEnable_o       = out_valid;
    assign bus.laneValid_o          = out_valid ? mem_lv_q[rd_ptr_q]   : '0;
    assign bus.instFormat_o         = out_valid ? mem_fmt_q[rd_ptr_q]  : '0;
    assign bus.instOpcode_o         = out_valid ? mem_opc_q[rd_ptr_q]  : '0;
    assign bus.illegal_o            = out_valid ? mem_ill_q[rd_ptr_q]  : '0;
    assign bus.instruction_o        = out_valid ? mem_ins_q[rd_ptr_q]  : '0;
    assign bus.instructionAddress_o = out_valid ? mem_addr_q[rd_ptr_q] : '0;
    assign bus.instructionMajId_o   = out_valid ? mem_maj_q[rd_ptr_q]  : '0;
    assign bus.instructionPid_o     = out_valid ? mem_pid_q[rd_ptr_q]  : '0;
    assign bus.instructionTid_o     = out_valid ? mem_tid_q[rd_ptr_q]  : '0;
endmodule

`default_nettype wire
